// File: rtl/bcd_timekeeper.sv
// BCD hh:mm:ss time-of-day counter with a once-per-second prescaler,
// validated load port and a self-clearing alarm ring request.
module bcd_timekeeper #(
  parameter int CLK_HZ    = 100000000,
  parameter int RING_SECS = 60
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic [23:0] load_time,
  input  logic        run_en,
  input  logic [23:0] alarm_time,
  input  logic        alarm_en,
  input  logic        alarm_ack,
  output logic [23:0] time_bcd,
  output logic        sec_tick,
  output logic        alarm_ring,
  output logic        load_err
);

  localparam int              PW        = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [PW-1:0]   PRE_LAST  = PW'(CLK_HZ - 1);
  localparam logic [7:0]      RING_LAST = 8'(RING_SECS);

  typedef struct packed {
    logic [3:0] ht;
    logic [3:0] ho;
    logic [3:0] mt;
    logic [3:0] mo;
    logic [3:0] st;
    logic [3:0] so;
  } hms_t;

  typedef enum logic {
    IDLE,
    RINGING
  } ring_state_t;

  function automatic logic time_valid(input hms_t t);
    return (t.ht <= 4'd2) && (t.ho <= 4'd9) && ((t.ht != 4'd2) || (t.ho <= 4'd3)) &&
           (t.mt <= 4'd5) && (t.mo <= 4'd9) && (t.st <= 4'd5) && (t.so <= 4'd9);
  endfunction

  // Ripple carry through the digits; hours roll 23 -> 00 as a BCD pair.
  function automatic hms_t time_inc(input hms_t t);
    hms_t n;
    n = t;
    if (t.so != 4'd9) begin
      n.so = t.so + 4'd1;
    end else begin
      n.so = 4'd0;
      if (t.st != 4'd5) begin
        n.st = t.st + 4'd1;
      end else begin
        n.st = 4'd0;
        if (t.mo != 4'd9) begin
          n.mo = t.mo + 4'd1;
        end else begin
          n.mo = 4'd0;
          if (t.mt != 4'd5) begin
            n.mt = t.mt + 4'd1;
          end else begin
            n.mt = 4'd0;
            if ((t.ht == 4'd2) && (t.ho == 4'd3)) begin
              n.ht = 4'd0;
              n.ho = 4'd0;
            end else if (t.ho == 4'd9) begin
              n.ht = t.ht + 4'd1;
              n.ho = 4'd0;
            end else begin
              n.ho = t.ho + 4'd1;
            end
          end
        end
      end
    end
    return n;
  endfunction

  hms_t          cur_q;
  hms_t          load_t;
  logic [PW-1:0] pre_q;
  logic          sec_tick_q;
  logic          load_err_q;
  logic          upd_q;
  logic          load_ok;
  logic          load_bad;
  logic          tick;
  logic          step;
  logic          match;
  ring_state_t   state_q, state_d;
  logic [7:0]    ring_cnt_q, ring_cnt_d;

  assign load_t   = hms_t'(load_time);
  assign load_ok  = load && time_valid(load_t);
  assign load_bad = load && !time_valid(load_t);
  assign tick     = run_en && (pre_q == PRE_LAST);
  // A valid load on the tick cycle swallows that second's increment.
  assign step     = tick && !load_ok;
  // Equality only counts on the cycle right after the time was updated.
  assign match    = upd_q && alarm_en && (cur_q == hms_t'(alarm_time));

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_q      <= '0;
      pre_q      <= '0;
      sec_tick_q <= 1'b0;
      load_err_q <= 1'b0;
      upd_q      <= 1'b0;
    end else begin
      if (load_ok) begin
        pre_q <= '0;
      end else if (run_en) begin
        pre_q <= (pre_q == PRE_LAST) ? '0 : pre_q + 1'b1;
      end

      if (load_ok) begin
        cur_q <= load_t;
      end else if (step) begin
        cur_q <= time_inc(cur_q);
      end

      if (load_ok) begin
        load_err_q <= 1'b0;
      end else if (load_bad) begin
        load_err_q <= 1'b1;
      end

      sec_tick_q <= step;
      upd_q      <= step || load_ok;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      ring_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      ring_cnt_q <= ring_cnt_d;
    end
  end

  // NOTE: every always_comb output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_d    = state_q;
    ring_cnt_d = ring_cnt_q;
    unique case (state_q)
      IDLE: begin
        if (match) begin
          state_d    = RINGING;
          ring_cnt_d = '0;
        end
      end
      RINGING: begin
        if (alarm_ack || !alarm_en || (ring_cnt_q == RING_LAST)) begin
          state_d    = IDLE;
          ring_cnt_d = '0;
        end else if (match) begin
          ring_cnt_d = '0;
        end else if (step) begin
          ring_cnt_d = ring_cnt_q + 8'd1;
        end
      end
      default: begin
        state_d    = IDLE;
        ring_cnt_d = '0;
      end
    endcase
  end

  assign time_bcd   = cur_q;
  assign sec_tick   = sec_tick_q;
  assign load_err   = load_err_q;
  assign alarm_ring = (state_q == RINGING);

endmodule

// File: tb/tb_bcd_timekeeper.sv
// Self-checking bench for bcd_timekeeper: directed corner sequences, a
// load-validity vector table and a randomized run against an integer model.
module tb_bcd_timekeeper;

  localparam int CLK_HZ    = 4;
  localparam int RING_SECS = 3;
  localparam int DAY       = 86400;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        load = 1'b0;
  logic [23:0] load_time = '0;
  logic        run_en = 1'b0;
  logic [23:0] alarm_time = '0;
  logic        alarm_en = 1'b0;
  logic        alarm_ack = 1'b0;
  logic [23:0] time_bcd;
  logic        sec_tick;
  logic        alarm_ring;
  logic        load_err;

  int n_tests = 0;
  int n_fail  = 0;

  bcd_timekeeper #(.CLK_HZ(CLK_HZ), .RING_SECS(RING_SECS)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (load),
    .load_time (load_time),
    .run_en    (run_en),
    .alarm_time(alarm_time),
    .alarm_en  (alarm_en),
    .alarm_ack (alarm_ack),
    .time_bcd  (time_bcd),
    .sec_tick  (sec_tick),
    .alarm_ring(alarm_ring),
    .load_err  (load_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model: whole seconds of the day ----------------
  int m_secs, m_pre, m_cnt;
  bit m_err, m_ring, m_tick, m_upd;

  function automatic int bcd_to_secs(input logic [23:0] b);
    return (b[23:20] * 10 + b[19:16]) * 3600 + (b[15:12] * 10 + b[11:8]) * 60 +
           b[7:4] * 10 + b[3:0];
  endfunction

  function automatic logic [23:0] secs_to_bcd(input int s);
    int h, m, x;
    h = s / 3600;
    m = (s / 60) % 60;
    x = s % 60;
    return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10), 4'(x / 10), 4'(x % 10)};
  endfunction

  function automatic bit legal_time(input logic [23:0] b);
    return (b[23:20] <= 2) && (b[19:16] <= 9) && (b[23:20] * 10 + b[19:16] <= 23) &&
           (b[15:12] <= 5) && (b[11:8] <= 9) && (b[7:4] <= 5) && (b[3:0] <= 9);
  endfunction

  task automatic m_reset();
    m_secs = 0; m_pre = 0; m_cnt = 0;
    m_err = 0; m_ring = 0; m_tick = 0; m_upd = 0;
  endtask

  task automatic m_step(input bit ld, input logic [23:0] lt, input bit run,
                        input logic [23:0] at, input bit aen, input bit ack);
    bit ok, adv, hit;
    ok  = ld && legal_time(lt);
    adv = run && (m_pre == CLK_HZ - 1) && !ok;
    hit = m_upd && aen && (secs_to_bcd(m_secs) == at);
    if (!m_ring) begin
      if (hit) begin m_ring = 1; m_cnt = 0; end
    end else if (ack || !aen || m_cnt == RING_SECS) begin
      m_ring = 0; m_cnt = 0;
    end else if (hit) begin
      m_cnt = 0;
    end else if (adv) begin
      m_cnt++;
    end
    if (ok) m_pre = 0;
    else if (run) m_pre = (m_pre + 1) % CLK_HZ;
    if (ok) m_secs = bcd_to_secs(lt);
    else if (adv) m_secs = (m_secs + 1) % DAY;
    if (ok) m_err = 0;
    else if (ld) m_err = 1;
    m_tick = adv;
    m_upd  = adv || ok;
  endtask

  // One clock: advance the model with the inputs seen at the edge, compare after.
  task automatic cyc();
    @(posedge clk);
    m_step(load, load_time, run_en, alarm_time, alarm_en, alarm_ack);
    #1;
    check("model_time", time_bcd, secs_to_bcd(m_secs));
    check("model_tick", sec_tick, m_tick);
    check("model_ring", alarm_ring, m_ring);
    check("model_err",  load_err, m_err);
  endtask

  task automatic wait_tick(input int maxc, output int n);
    n = 0;
    do begin
      cyc();
      n++;
    end while (!sec_tick && n < maxc);
    check("tick_within_bound", sec_tick, 1'b1);
  endtask

  task automatic do_load(input logic [23:0] lt);
    load = 1'b1;
    load_time = lt;
    cyc();
    load = 1'b0;
  endtask

  typedef struct {
    logic [23:0] lt;
    logic [23:0] exp_time;
    logic        exp_err;
  } ld_vec_t;

  ld_vec_t vecs[11];

  initial begin
    int n, hi, r;

    vecs[0]  = '{24'h101010, 24'h101010, 1'b0};
    vecs[1]  = '{24'h245000, 24'h101010, 1'b1};
    vecs[2]  = '{24'h075960, 24'h101010, 1'b1};
    vecs[3]  = '{24'h075959, 24'h075959, 1'b0};
    vecs[4]  = '{24'h240000, 24'h075959, 1'b1};
    vecs[5]  = '{24'h235959, 24'h235959, 1'b0};
    vecs[6]  = '{24'h190000, 24'h190000, 1'b0};
    vecs[7]  = '{24'h006000, 24'h190000, 1'b1};
    vecs[8]  = '{24'h0a0000, 24'h190000, 1'b1};
    vecs[9]  = '{24'h000000, 24'h000000, 1'b0};
    vecs[10] = '{24'h129959, 24'h000000, 1'b1};

    // Reset state
    m_reset();
    #7;
    check("rst_time", time_bcd, 24'h000000);
    check("rst_tick", sec_tick, 1'b0);
    check("rst_ring", alarm_ring, 1'b0);
    check("rst_err",  load_err, 1'b0);
    #1 rst_n = 1'b1;

    // Free run: every tick exactly CLK_HZ cycles apart, ten seconds elapse
    run_en = 1'b1;
    for (int i = 0; i < 10; i++) begin
      wait_tick(20, n);
      check("tick_period", n, CLK_HZ);
    end
    check("ten_secs", time_bcd, 24'h000010);

    // Midnight rollover
    do_load(24'h235958);
    wait_tick(20, n);
    check("pre_midnight", time_bcd, 24'h235959);
    wait_tick(20, n);
    check("midnight", time_bcd, 24'h000000);
    check("midnight_err", load_err, 1'b0);

    // Load validity table, clock frozen
    run_en = 1'b0;
    for (int i = 0; i < 11; i++) begin
      do_load(vecs[i].lt);
      check("tbl_time", time_bcd, vecs[i].exp_time);
      check("tbl_err",  load_err, vecs[i].exp_err);
      check("tbl_tick", sec_tick, 1'b0);
    end

    // Load coinciding with the tick edge wins
    run_en = 1'b1;
    wait_tick(20, n);
    repeat (CLK_HZ - 1) cyc();
    do_load(24'h120000);
    check("tickload_time", time_bcd, 24'h120000);
    check("tickload_tick", sec_tick, 1'b0);
    wait_tick(20, n);
    check("tickload_gap", n, CLK_HZ);
    check("tickload_next", time_bcd, 24'h120001);

    // Alarm rings for RING_SECS ticks then self-clears
    run_en = 1'b0;
    alarm_time = 24'h060001;
    alarm_en = 1'b1;
    do_load(24'h060000);
    cyc();
    check("alarm_no_early", alarm_ring, 1'b0);
    run_en = 1'b1;
    wait_tick(20, n);
    check("alarm_reach", time_bcd, 24'h060001);
    check("alarm_latency0", alarm_ring, 1'b0);
    cyc();
    check("alarm_rise", alarm_ring, 1'b1);
    hi = 1;
    while (alarm_ring && hi < 40) begin
      cyc();
      if (alarm_ring) hi++;
    end
    check("ring_length", hi, RING_SECS * CLK_HZ);

    // Acknowledge mid-ring
    run_en = 1'b0;
    do_load(24'h060000);
    run_en = 1'b1;
    wait_tick(20, n);
    cyc();
    check("ack_rise", alarm_ring, 1'b1);
    repeat (5) cyc();
    alarm_ack = 1'b1;
    cyc();
    alarm_ack = 1'b0;
    check("ack_stop", alarm_ring, 1'b0);

    // Ring from a load alone, then asynchronous reset mid-ring
    run_en = 1'b0;
    do_load(24'h060001);
    check("ldring_latency0", alarm_ring, 1'b0);
    cyc();
    check("ldring_rise", alarm_ring, 1'b1);
    repeat (2) cyc();
    #2 rst_n = 1'b0;
    #1;
    check("async_ring", alarm_ring, 1'b0);
    check("async_time", time_bcd, 24'h000000);
    m_reset();
    #2 rst_n = 1'b1;

    // Randomized run against the model
    alarm_time = secs_to_bcd(2);
    for (int i = 0; i < 3000; i++) begin
      run_en    = ($urandom_range(0, 9) != 0);
      alarm_en  = ($urandom_range(0, 19) != 0);
      alarm_ack = ($urandom_range(0, 29) == 0);
      load      = ($urandom_range(0, 24) == 0);
      r = $urandom_range(0, 9);
      if (r < 5)       load_time = secs_to_bcd($urandom_range(0, DAY - 1));
      else if (r < 7)  load_time = alarm_time;
      else if (r < 8)  load_time = secs_to_bcd(DAY - 2);
      else             load_time = 24'($urandom);
      if ($urandom_range(0, 49) == 0)
        alarm_time = secs_to_bcd((m_secs + $urandom_range(1, 3)) % DAY);
      cyc();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/bcd_timekeeper.md
Name: bcd_timekeeper

Overview:
- Time-of-day counter that consumes the 24-bit BCD hh:mm:ss word produced by the time-entry block.
- Holds the running clock, advances it once per second and raises an alarm ring request.
- Its time_bcd output feeds the 7-segment scan FSM when the mode selects clock display, and alarm_ring drives sndOn/speaker gating in top.

Parameters:
- CLK_HZ, 100000000, input clock cycles per second; the prescaler divides by this value (a bench uses 4).
- RING_SECS, 60, number of second ticks the alarm rings before self-clearing (range 1..255).

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- load  input  1  level-sampled; a high cycle requests loading load_time
- load_time  input  24  BCD {hT,hO,mT,mO,sT,sO}, 4 bits each, MSB = hours tens
- run_en  input  1  1 = clock advances; 0 = frozen, prescaler holds
- alarm_time  input  24  BCD alarm setting, same layout
- alarm_en  input  1  alarm armed
- alarm_ack  input  1  stops an active ring
- time_bcd  output  24  current time, registered
- sec_tick  output  1  one-cycle pulse on each second increment
- alarm_ring  output  1  registered ring request
- load_err  output  1  sticky flag: last load attempt was an invalid time

Behaviour:
- Reset (async, rst_n=0):
  - time_bcd=24'h000000, prescaler=0, sec_tick=0, alarm_ring=0, load_err=0.
  - Ring counter=0; FSM goes to IDLE.
- Prescaler:
  - Counts 0..CLK_HZ-1 while run_en=1 and holds while run_en=0.
  - Terminal count produces an internal tick and wraps the prescaler to 0.
  - First tick after reset or load comes exactly CLK_HZ enabled cycles later.
- Increment on tick (same edge; sec_tick=1 for that one cycle):
  - sO 9->0 carries to sT; sT 5->0 carries to mO; mO 9->0 carries to mT; mT 5->0 carries to hours.
  - Hours increment as a BCD pair 00..23; 23:59:59 -> 00:00:00.
- Load validity: hT<=2, hO<=9, and hours<=23, mT<=5, mO<=9, sT<=5, sO<=9.
  - Valid load: time_bcd<=load_time next edge, prescaler<=0, load_err<=0, no sec_tick.
  - Invalid load: time_bcd unchanged, load_err<=1; load_err stays 1 until the next valid load or reset.
  - Load asserted on a tick cycle: load wins, the increment is discarded, sec_tick=0.
  - Load held high for several cycles reloads every cycle, so the prescaler stays at 0.
- Alarm FSM, states IDLE and RINGING:
  - Match event = cycle after a tick or valid load where time_bcd==alarm_time and alarm_en=1. Only update-caused equality counts, so holding equality never retriggers.
  - IDLE -> RINGING on a match event: alarm_ring=1 from the edge following the update (1-cycle latency), ring counter=0.
  - While RINGING, ring counter increments on each tick.
  - RINGING -> IDLE, with alarm_ring=0 next edge, when any of these holds:
    - alarm_ack=1
    - alarm_en=0
    - ring counter reaches RING_SECS
  - A match event while already RINGING restarts the ring counter.
  - alarm_ack in IDLE has no effect.
  - Changing alarm_time while RINGING does not stop the ring.
- Reset mid-operation: all state cleared immediately (asynchronous), including an active ring.
- Invalid BCD is never produced internally; time_bcd always holds a legal time.

Test Plan:
- Bench uses CLK_HZ=4, RING_SECS=3.
- Reset then run_en=1 -> time_bcd=000000; sec_tick pulses every 4 cycles; after 10 ticks time_bcd=000010.
- Load 235958, run -> ticks give 235959, then 000000. load_err=0 throughout.
- Load 245000 after a valid time 101010 -> time_bcd stays 101010 and load_err=1. Then load 075960 -> still invalid, load_err stays 1. Then load 075959 -> time_bcd=075959, load_err=0.
- Assert load=1 on the exact tick cycle with load_time=120000 -> time_bcd=120000, sec_tick=0; next sec_tick arrives exactly 4 cycles after load drops.
- alarm_time=060001, alarm_en=1, load 060000, run:
  - On reaching 060001, alarm_ring=1 one cycle later and stays high for 3 ticks, then 0.
  - Repeat and pulse alarm_ack mid-ring -> alarm_ring=0 next edge.
- With run_en=0, load 060001 while alarm_time=060001 and alarm_en=1 -> ring starts without ticks. Deassert rst_n mid-ring -> alarm_ring=0 and time_bcd=000000 immediately.
